message_datapath: RTL and testbench
===================================

Name: message_datapath

Overview:
- Datapath stage that sits directly under the message controller and executes its ld / cnt1 / shift commands.
- Holds one message word, times each bit with a tick counter, counts transmitted bits and drives a serial output MSB-first.
- Returns co1 (bit period elapsed) and co2 (last bit reached) to the controller's state machine.

Parameters:
MSG_W, 8, message width in bits (>= 2)
BIT_TICKS, 4, cnt1 cycles per bit period (>= 2)
TICK_W, 2, tick counter width; must hold BIT_TICKS-1
BIT_W, 3, bit counter width; must hold MSG_W-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (rst = 0 resets)
ld  input  1  load msg_in, clear counters, start message
cnt1  input  1  advance bit-period tick counter
shift  input  1  advance to next message bit
msg_in  input  MSG_W  message word, sampled on ld
co1  output  1  tick counter at terminal count
co2  output  1  bit counter at last bit
sout  output  1  current serial bit (MSB of message register)
busy  output  1  message loaded and not fully shifted

Behaviour:
- State: msg_reg[MSG_W], tick_cnt[TICK_W], bit_cnt[BIT_W], busy_r. All are flops on clk; rst asynchronous.
- Reset (rst = 0, any time, including mid-message):
  - msg_reg = 0, tick_cnt = 0, bit_cnt = 0, busy = 0, taking effect immediately without waiting for clk.
  - Outputs: sout = 0, co1 = 0, co2 = 0.
  - On rst release, the block is idle and waits for ld.
- Combinational outputs (no added latency):
  - sout = msg_reg[MSG_W-1]
  - co1 = (tick_cnt == BIT_TICKS-1)
  - co2 = (bit_cnt == MSG_W-1)
  - busy = busy_r
- ld (highest priority; cnt1 and shift are ignored in the same cycle):
  - msg_reg <= msg_in, tick_cnt <= 0, bit_cnt <= 0, busy_r <= 1.
  - Accepted whether idle or busy; ld while busy aborts and restarts the message.
- cnt1 (when busy_r = 1 and ld = 0):
  - If tick_cnt == BIT_TICKS-1, tick_cnt <= 0 (wrap); otherwise tick_cnt <= tick_cnt + 1.
- shift (when busy_r = 1 and ld = 0):
  - msg_reg <= {msg_reg[MSG_W-2:0], 1'b0}.
  - If bit_cnt == MSG_W-1: bit_cnt <= 0, busy_r <= 0 (message complete). Otherwise bit_cnt <= bit_cnt + 1.
- cnt1 and shift asserted together (and ld = 0, busy_r = 1): both actions happen independently in the same cycle.
- busy_r = 0: cnt1 and shift are ignored; all registers hold.
- Timing with the controller's Init -> S1 (cnt1) -> S2 (shift) loop:
  - Each bit is visible on sout for BIT_TICKS + 1 cycles.
  - co2 is high throughout the last bit, so the controller exits after the final shift.
- After the final shift: msg_reg = 0 (zero-filled), sout = 0, co2 = 0, busy = 0.
- No overflow states: both counters wrap only at their terminal values; TICK_W/BIT_W sized per the parameter constraints.

Test Plan:
- Async reset: load 8'hA5, run 2 bits, drop rst between clock edges -> sout, co1, co2, busy all 0 before the next edge; idle after release.
- Load: ld=1 with msg_in=8'hA5 for one cycle -> next cycle busy=1, sout=1, co1=0, co2=0.
- Tick wrap: after ld, hold cnt1 for 3 cycles -> co1=1; a 4th cnt1 -> co1=0 and tick_cnt=0; sout unchanged at 1.
- Full message: drive the controller pattern (4x cnt1, 1x shift) x 8 on 8'hA5 -> sout = 1,0,1,0,0,1,0,1, each held 5 cycles; co2=1 only during bit 8; after the 8th shift busy=0, sout=0.
- Abort/reload: mid-message at bit 3, ld with 8'h3C -> sout=0, bit_cnt=0, tick_cnt=0; the sequence restarts 0,0,1,1,1,1,0,0.
- Priority/idle: when idle, shift/cnt1 -> no change (busy=0, co1=0). While busy, ld+shift+cnt1 together with 8'h80 -> only the load occurs (sout=1, counters 0). shift+cnt1 together -> bit advances and tick increments in the same cycle.

Source files
------------

// File: rtl/message_datapath.sv
// Message word register, bit-period tick counter and bit counter driving sout MSB-first.
// Outputs are combinational from state. Commands take effect on the next clk edge, with no backpressure.
module message_datapath #(
    parameter int MSG_W     = 8,
    parameter int BIT_TICKS = 4,
    parameter int TICK_W    = 2,
    parameter int BIT_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             cnt1,
    input  logic             shift,
    input  logic [MSG_W-1:0] msg_in,
    output logic             co1,
    output logic             co2,
    output logic             sout,
    output logic             busy
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(MSG_W - 1);

    logic [MSG_W-1:0]  msg_q,  msg_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [BIT_W-1:0]  bit_q,  bit_d;
    logic              busy_q, busy_d;

    always_comb begin
        msg_d  = msg_q;
        tick_d = tick_q;
        bit_d  = bit_q;
        busy_d = busy_q;
        if (ld) begin
            // A load always restarts the message, even mid-transfer.
            msg_d  = msg_in;
            tick_d = '0;
            bit_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt1) begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            if (shift) begin
                msg_d = {msg_q[MSG_W-2:0], 1'b0};
                if (bit_q == BIT_LAST) begin
                    bit_d  = '0;
                    busy_d = 1'b0;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg_q  <= '0;
            tick_q <= '0;
            bit_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            msg_q  <= msg_d;
            tick_q <= tick_d;
            bit_q  <= bit_d;
            busy_q <= busy_d;
        end
    end

    assign sout = msg_q[MSG_W-1];
    assign co1  = (tick_q == TICK_LAST);
    assign co2  = (bit_q == BIT_LAST);
    assign busy = busy_q;

endmodule

// File: tb/tb_message_datapath.sv
// Directed bench for message_datapath: reset, load, tick wrap, full message, abort and command priority.
module tb_message_datapath;

    logic       clk;
    logic       rst;
    logic       ld;
    logic       cnt1;
    logic       shift;
    logic [7:0] msg_in;
    logic       co1;
    logic       co2;
    logic       sout;
    logic       busy;

    int checks = 0;
    int errors = 0;

    message_datapath #(.MSG_W(8), .BIT_TICKS(4), .TICK_W(2), .BIT_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .ld     (ld),
        .cnt1   (cnt1),
        .shift  (shift),
        .msg_in (msg_in),
        .co1    (co1),
        .co2    (co2),
        .sout   (sout),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given commands, then commands drop and outputs are settled for sampling.
    task automatic step(input logic l, input logic c, input logic s, input logic [7:0] m);
        ld     = l;
        cnt1   = c;
        shift  = s;
        msg_in = m;
        @(posedge clk);
        #1;
        ld    = 1'b0;
        cnt1  = 1'b0;
        shift = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({sout, co1, co2, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: sout/co1/co2/busy = %b, expected 0000", {sout, co1, co2, busy});
        end
    endtask

    task automatic test_load;
        step(1'b1, 1'b0, 1'b0, 8'hA5);
        checks++;
        if ({busy, sout, co1, co2} !== 4'b1100) begin
            errors++;
            $display("FAIL load: busy/sout/co1/co2 = %b, expected 1100", {busy, sout, co1, co2});
        end
    endtask

    task automatic test_tick_wrap;
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            checks++;
            if (co1 !== (i == 3)) begin
                errors++;
                $display("FAIL tick_wrap_co1[%0d]: co1 = %b, expected %b", i, co1, (i == 3));
            end
            checks++;
            if (sout !== 1'b1) begin
                errors++;
                $display("FAIL tick_wrap_sout[%0d]: sout = %b, expected 1", i, sout);
            end
        end
    endtask

    task automatic test_full_message;
        logic [7:0] exp_bits;
        exp_bits = 8'hA5;
        step(1'b1, 1'b0, 1'b0, 8'hA5);
        for (int b = 0; b < 8; b++) begin
            for (int t = 0; t < 5; t++) begin
                checks++;
                if (sout !== exp_bits[7-b] || co2 !== (b == 7) || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL full_msg bit%0d cyc%0d: sout/co2/busy = %b%b%b, expected %b%b1",
                             b, t, sout, co2, busy, exp_bits[7-b], (b == 7));
                end
                if (t < 4) step(1'b0, 1'b1, 1'b0, 8'h00);
            end
            step(1'b0, 1'b0, 1'b1, 8'h00);
        end
        checks++;
        if ({busy, sout, co2} !== 3'b000) begin
            errors++;
            $display("FAIL full_msg_end: busy/sout/co2 = %b, expected 000", {busy, sout, co2});
        end
    endtask

    task automatic test_abort_reload;
        logic [7:0] exp_bits;
        exp_bits = 8'h3C;
        step(1'b1, 1'b0, 1'b0, 8'hA5);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (sout !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: sout = %b, expected 1", sout);
        end
        step(1'b1, 1'b0, 1'b0, 8'h3C);
        checks++;
        if ({busy, sout, co1, co2} !== 4'b1000) begin
            errors++;
            $display("FAIL abort_reload: busy/sout/co1/co2 = %b, expected 1000", {busy, sout, co1, co2});
        end
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            checks++;
            if (co1 !== (i == 3)) begin
                errors++;
                $display("FAIL abort_tick[%0d]: co1 = %b, expected %b", i, co1, (i == 3));
            end
        end
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (sout !== exp_bits[7-b] || co2 !== (b == 7)) begin
                errors++;
                $display("FAIL abort_seq bit%0d: sout/co2 = %b%b, expected %b%b",
                         b, sout, co2, exp_bits[7-b], (b == 7));
            end
            step(1'b0, 1'b0, 1'b1, 8'h00);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_end: busy = %b, expected 0", busy);
        end
    endtask

    task automatic test_priority_idle;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'h00);
        checks++;
        if ({busy, co1, sout, co2} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_ignore: busy/co1/sout/co2 = %b, expected 0000", {busy, co1, sout, co2});
        end
        step(1'b1, 1'b0, 1'b0, 8'hA5);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'h80);
        checks++;
        if ({busy, sout, co1, co2} !== 4'b1100) begin
            errors++;
            $display("FAIL ld_priority: busy/sout/co1/co2 = %b, expected 1100", {busy, sout, co1, co2});
        end
        step(1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (co1 !== 1'b0) begin
            errors++;
            $display("FAIL ld_tick_clear: co1 = %b, expected 0", co1);
        end
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h00);
        checks++;
        if ({sout, co1, busy} !== 3'b011) begin
            errors++;
            $display("FAIL shift_cnt_together: sout/co1/busy = %b, expected 011", {sout, co1, busy});
        end
    endtask

    task automatic test_async_reset;
        step(1'b1, 1'b0, 1'b0, 8'hA5);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if ({busy, sout, co1} !== 3'b111) begin
            errors++;
            $display("FAIL async_pre: busy/sout/co1 = %b, expected 111", {busy, sout, co1});
        end
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({sout, co1, co2, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: sout/co1/co2/busy = %b, expected 0000", {sout, co1, co2, busy});
        end
        #2;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'h00);
        checks++;
        if ({sout, co1, co2, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL async_idle_after: sout/co1/co2/busy = %b, expected 0000", {sout, co1, co2, busy});
        end
    endtask

    initial begin
        rst    = 1'b0;
        ld     = 1'b0;
        cnt1   = 1'b0;
        shift  = 1'b0;
        msg_in = 8'h00;
        #12;
        test_reset();
        rst = 1'b1;
        test_load();
        test_tick_wrap();
        test_full_message();
        test_abort_reload();
        test_priority_idle();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
